// File: rtl/reg_map_pkg.sv
// Register map shared by the write arbiter and its consumers: address
// constants, widths, reset values and the grant encoding.
package reg_map_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  localparam logic [DATA_W-1:0] REG_RESET_VAL [NUM_REGS] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the requester that was not
// granted most recently, and the pointer only moves on a grant.
module rr_arb2
  import reg_map_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  grant_e last_grant;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == GRANT_REQ1) ? 2'b01 : 2'b10;
    end
  end

  // Reset points at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_REQ1;
    end else if (grant[0]) begin
      last_grant <= GRANT_REQ0;
    end else if (grant[1]) begin
      last_grant <= GRANT_REQ1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates writes from the SPI decoder and the sequencer into the
// configuration register bank; unmapped writes are accepted and flagged.
module reg_write_arbiter
  import reg_map_pkg::NUM_REGS;
  import reg_map_pkg::REG_RESET_VAL;
#(
  parameter int ADDR_W = reg_map_pkg::ADDR_W,
  parameter int DATA_W = reg_map_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic [DATA_W-1:0]   en_reg_out_7_0,
  output logic [DATA_W-1:0]   en_reg_out_15_8,
  output logic [DATA_W-1:0]   en_reg_pwm_7_0,
  output logic [DATA_W-1:0]   en_reg_pwm_15_8,
  output logic [DATA_W-1:0]   pwm_duty_cycle,
  output logic [NUM_REGS-1:0] reg_update,
  output logic                addr_err
);

  logic [1:0]        grant;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign wr_en      = |grant;
  assign wr_addr    = grant[1] ? req1_addr : req0_addr;
  assign wr_data    = grant[1] ? req1_data : req0_data;

  // reg_update and addr_err are single-cycle pulses, cleared every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= REG_RESET_VAL[i];
      end
      reg_update <= '0;
      addr_err   <= 1'b0;
    end else begin
      reg_update <= '0;
      addr_err   <= 1'b0;
      if (wr_en) begin
        if (wr_addr < ADDR_W'(NUM_REGS)) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
              regs_q[i]     <= wr_data;
              reg_update[i] <= 1'b1;
            end
          end
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: each granted write updates a
// reference register model and queues the outputs expected one cycle later.
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [4:0]  upd;
    logic        err;
    logic [39:0] regs;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [6:0] req0_addr = '0;
  logic [7:0] req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [6:0] req1_addr = '0;
  logic [7:0] req1_data = '0;
  logic       req1_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic [4:0] reg_update;
  logic       addr_err;

  obs_t       exp_q [$];
  logic [7:0] model_regs [5];
  int         n_checks = 0;
  int         n_fail = 0;

  reg_write_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .reg_update      (reg_update),
    .addr_err        (addr_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {reg_update, addr_err, pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
            en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_packed();
    return {model_regs[4], model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
    exp_q.delete();
  endtask

  // Expected effect of the write the bench intends to be granted this cycle.
  task automatic model_push(input logic [1:0] g, input logic [6:0] a0, input logic [7:0] d0,
                            input logic [6:0] a1, input logic [7:0] d1);
    obs_t       it;
    logic [6:0] a;
    logic [7:0] d;
    it = '0;
    if (g != 2'b00) begin
      a = g[0] ? a0 : a1;
      d = g[0] ? d0 : d1;
      if (a <= 7'h04) begin
        model_regs[int'(a)] = d;
        it.upd[int'(a)] = 1'b1;
      end else begin
        it.err = 1'b1;
      end
    end
    it.regs = model_packed();
    exp_q.push_back(it);
  endtask

  task automatic step(input logic v0, input logic [6:0] a0, input logic [7:0] d0,
                      input logic v1, input logic [6:0] a1, input logic [7:0] d1,
                      input logic [1:0] exp_g, output logic [1:0] got_g,
                      output obs_t got, output obs_t expv);
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    got_g = {req1_ready, req0_ready};
    model_push(exp_g, a0, d0, a1, d1);
    @(posedge clk);
    #1;
    got  = sample();
    expv = exp_q.pop_front();
  endtask

  task automatic test_reset();
    obs_t o;
    model_clear();
    #1;
    req0_valid = 1'($urandom); req0_addr = 7'($urandom); req0_data = 8'($urandom);
    req1_valid = 1'($urandom); req1_addr = 7'($urandom); req1_data = 8'($urandom);
    reset = 1'b0;
    #2;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h expected %h", o, obs_t'(0));
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_idle();
    logic [1:0] g;
    obs_t o, e;
    step(1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 2'b00, g, o, e);
    n_checks++;
    if (g !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_ready: got %b expected 00", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL idle_out: got %h expected %h", o, e); end
  endtask

  task automatic test_single_writer();
    logic [1:0] g;
    obs_t o, e;
    step(1'b1, 7'h04, 8'h80, 1'b0, 7'h00, 8'h00, 2'b01, g, o, e);
    n_checks++;
    if (g !== 2'b01) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 01", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL single_out: got %h expected %h", o, e); end
    n_checks++;
    if (o.upd !== 5'b10000) begin n_fail++; $display("[TB] FAIL single_update: got %b expected 10000", o.upd); end
    step(1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 2'b00, g, o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL single_pulse_end: got %h expected %h", o, e); end
  endtask

  task automatic test_reset_async();
    obs_t o;
    @(negedge clk);
    req0_valid = 1'($urandom); req0_addr = 7'($urandom); req0_data = 8'($urandom);
    req1_valid = 1'($urandom); req1_addr = 7'($urandom); req1_data = 8'($urandom);
    #2;
    reset = 1'b0;
    #1;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0)) begin n_fail++; $display("[TB] FAIL async_reset: got %h expected %h", o, obs_t'(0)); end
    @(posedge clk);
    #1;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0)) begin n_fail++; $display("[TB] FAIL async_reset_hold: got %h expected %h", o, obs_t'(0)); end
    model_clear();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0] g, eg;
    obs_t o, e;
    for (int c = 0; c < 4; c++) begin
      eg = (c % 2 == 0) ? 2'b01 : 2'b10;
      step(1'b1, 7'h00, 8'hAA, 1'b1, 7'h01, 8'h55, eg, g, o, e);
      n_checks++;
      if (g !== eg) begin n_fail++; $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", c, g, eg); end
      n_checks++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL contention_out[%0d]: got %h expected %h", c, o, e); end
    end
    n_checks++;
    if (en_reg_out_7_0 !== 8'hAA) begin n_fail++; $display("[TB] FAIL contention_reg0: got %h expected aa", en_reg_out_7_0); end
    n_checks++;
    if (en_reg_out_15_8 !== 8'h55) begin n_fail++; $display("[TB] FAIL contention_reg1: got %h expected 55", en_reg_out_15_8); end
  endtask

  task automatic test_same_reg_race();
    logic [1:0] g;
    obs_t o, e;
    step(1'b1, 7'h02, 8'h11, 1'b1, 7'h02, 8'h22, 2'b01, g, o, e);
    n_checks++;
    if (g !== 2'b01) begin n_fail++; $display("[TB] FAIL race_grant0: got %b expected 01", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL race_out0: got %h expected %h", o, e); end
    step(1'b0, 7'h00, 8'h00, 1'b1, 7'h02, 8'h22, 2'b10, g, o, e);
    n_checks++;
    if (g !== 2'b10) begin n_fail++; $display("[TB] FAIL race_grant1: got %b expected 10", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL race_out1: got %h expected %h", o, e); end
    n_checks++;
    if (en_reg_pwm_7_0 !== 8'h22) begin n_fail++; $display("[TB] FAIL race_final: got %h expected 22", en_reg_pwm_7_0); end
    step(1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 2'b00, g, o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL race_idle: got %h expected %h", o, e); end
  endtask

  task automatic test_unmapped();
    logic [1:0] g;
    obs_t o, e;
    step(1'b0, 7'h00, 8'h00, 1'b1, 7'h05, 8'hFF, 2'b10, g, o, e);
    n_checks++;
    if (g !== 2'b10) begin n_fail++; $display("[TB] FAIL unmapped_ready: got %b expected 10", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL unmapped_out: got %h expected %h", o, e); end
    step(1'b1, 7'h7F, 8'h01, 1'b0, 7'h00, 8'h00, 2'b01, g, o, e);
    n_checks++;
    if (g !== 2'b01) begin n_fail++; $display("[TB] FAIL unmapped_top_ready: got %b expected 01", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL unmapped_top_out: got %h expected %h", o, e); end
    step(1'b1, 7'h03, 8'h5A, 1'b0, 7'h00, 8'h00, 2'b01, g, o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL mapped_edge_out: got %h expected %h", o, e); end
    step(1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 2'b00, g, o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL unmapped_idle: got %h expected %h", o, e); end
  endtask

  task automatic test_reset_mid_handshake();
    logic [1:0] g;
    obs_t o, e;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 7'h00; req1_data = 8'h77;
    reset = 1'b0;
    #1;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0)) begin n_fail++; $display("[TB] FAIL midhs_reset: got %h expected %h", o, obs_t'(0)); end
    @(posedge clk);
    #1;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0)) begin n_fail++; $display("[TB] FAIL midhs_no_write: got %h expected %h", o, obs_t'(0)); end
    model_clear();
    @(negedge clk);
    req1_valid = 1'b0;
    reset = 1'b1;
    step(1'b1, 7'h01, 8'h33, 1'b1, 7'h00, 8'h44, 2'b01, g, o, e);
    n_checks++;
    if (g !== 2'b01) begin n_fail++; $display("[TB] FAIL midhs_first_grant: got %b expected 01", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL midhs_out0: got %h expected %h", o, e); end
    step(1'b0, 7'h00, 8'h00, 1'b1, 7'h00, 8'h44, 2'b10, g, o, e);
    n_checks++;
    if (g !== 2'b10) begin n_fail++; $display("[TB] FAIL midhs_second_grant: got %b expected 10", g); end
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL midhs_out1: got %h expected %h", o, e); end
    step(1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 2'b00, g, o, e);
    n_checks++;
    if (o !== e) begin n_fail++; $display("[TB] FAIL midhs_idle: got %h expected %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_writer();
    test_reset_async();
    test_contention();
    test_same_reg_race();
    test_unmapped();
    test_reset_mid_handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Two-requester write arbiter and owner of the five-entry configuration register bank (output enables, PWM enables, PWM duty cycle). It sits between the SPI transaction decoder (requester 0) and the on-chip sequencer (requester 1), grants one write per clock using round-robin priority, and drives the register outputs consumed by the output and PWM stages. Writes to unmapped addresses are accepted, dropped and flagged.

## Interface
- ADDR_W, 7, register address width
- DATA_W, 8, register data width
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 (SPI decoder) write request
- req0_addr  in  ADDR_W  requester 0 target address
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 grant, combinational
- req1_valid / req1_addr / req1_data  in  1 / ADDR_W / DATA_W  requester 1 (sequencer), same meaning
- req1_ready  out  1  requester 1 grant, combinational
- en_reg_out_7_0  out  8  address 0x00, reset 0x00
- en_reg_out_15_8  out  8  address 0x01, reset 0x00
- en_reg_pwm_7_0  out  8  address 0x02, reset 0x00
- en_reg_pwm_15_8  out  8  address 0x03, reset 0x00
- pwm_duty_cycle  out  8  address 0x04, reset 0x00
- reg_update  out  5  one-cycle pulse, bit n = register n written; reset 0
- addr_err  out  1  one-cycle pulse on an accepted write to address ≥ 0x05; reset 0

## Operation
- Transfer on reqN_valid && reqN_ready at a rising clk edge; at most one transfer per cycle.
- Requester rule: once valid is high, valid/addr/data stay stable until ready is seen; ready never depends on the other requester's data.
- Arbitration: only one valid → it is granted the same cycle. Both valid → grant the requester not granted most recently (last_grant pointer). Pointer updates only on a transfer.
- No valid → both ready low, pointer unchanged.
- Write decode: addresses 0x00–0x04 load req data into the matching register; addresses 0x05–0x7F are accepted (ready asserted, handshake completes), no register changes, addr_err pulses.
- reg_update bit set only for mapped writes; rewriting the same value still pulses.
- Starvation bound: with both requesters continuously valid, grants strictly alternate; a waiting requester is granted within 1 cycle.

## Timing
- ready: combinational from both valid inputs and last_grant, same cycle as valid.
- Register output, reg_update and addr_err: visible the cycle after the transfer edge (1-cycle latency), pulses last exactly one cycle.
- Back-to-back writes to the same register on consecutive cycles: final value is the later write; reg_update high both cycles.
- Reset asserted (any time, including mid-handshake): all registers, reg_update, addr_err → 0 immediately; last_grant → 1 so requester 0 wins the first tie after reset. Any unfinished handshake is lost; requester re-presents after reset.
- Reset deassertion synchronous to clk by the system reset synchroniser, not in this block.

## Structure
- Shared package reg_map_pkg: address constants ADDR_EN_OUT_LO=0x00 … ADDR_PWM_DUTY=0x04, NUM_REGS=5, ADDR_W, DATA_W, reset values.
- Sub-module rr_arb2: two-input round-robin arbiter (valid in, grant out, pointer register); top level holds the write mux, decode and register bank.

## Test plan
- Reset: drive random inputs, assert reset mid-cycle → all five registers 0x00, reg_update 0, addr_err 0 before next clk edge.
- Single writer: req0 writes 0x04←0x80 → req0_ready same cycle, pwm_duty_cycle=0x80 and reg_update=5'b10000 next cycle, one cycle wide.
- Contention: both valid continuously, req0→0x00 data 0xAA, req1→0x01 data 0x55 held for 4 cycles → first tie after reset grants req0, then grants alternate 0,1,0,1; both registers updated.
- Same-register race: req0 then req1 write 0x02 with 0x11 then 0x22 on consecutive grants → en_reg_pwm_7_0 ends 0x22, reg_update[2] high two cycles.
- Unmapped address: req1 writes 0x05 data 0xFF → req1_ready high, addr_err one-cycle pulse, all registers unchanged, reg_update 0.
- Reset mid-handshake: req1 valid, req0 idle, assert reset the same cycle → no register write; after release both valid → req0 granted first.
